// File: rtl/io_port_uart_tx_if.sv
// ---------------------------------------------------------------------------
// io_port_uart_tx_if
// Bundles the output-port word, the retransmit request and the UART status
// signals that travel between the memory stage and the UART transmitter.
//   port_data   [31:0] current value of the CPU output-port register
//   send_req           1-cycle pulse: resend port_data even if unchanged
//   tx                 UART serial line, idle high
//   busy               high while a frame is in progress
//   frame_done         1-cycle pulse when the final stop bit of a frame ends
//   frames_sent  [7:0] count of completed frames, wraps 255 -> 0
// master: the side that owns port_data/send_req (memory stage or bench)
// slave : the UART transmitter
// ---------------------------------------------------------------------------
interface io_port_uart_tx_if;
  logic [31:0] port_data;
  logic        send_req;
  logic        tx;
  logic        busy;
  logic        frame_done;
  logic [7:0]  frames_sent;

  modport master (
    output port_data, send_req,
    input  tx, busy, frame_done, frames_sent
  );

  modport slave (
    input  port_data, send_req,
    output tx, busy, frame_done, frames_sent
  );
endinterface

// File: rtl/io_port_uart_tx.sv
// ---------------------------------------------------------------------------
// io_port_uart_tx
// Watches the 32-bit output-port word and, whenever it changes (or a resend
// is requested), serialises it as NUM_BYTES back-to-back 8N1 UART characters,
// least-significant byte first, LSB of each byte first.
// Ports:
//   clk  system clock, rising-edge
//   rst  asynchronous, active-high reset
//   io   slave side of io_port_uart_tx_if (port_data, send_req in;
//        tx, busy, frame_done, frames_sent out)
// ---------------------------------------------------------------------------
module io_port_uart_tx #(
  parameter int CLKS_PER_BIT = 434,
  parameter int NUM_BYTES    = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  io_port_uart_tx_if.slave       io
);

  localparam int CNT_W  = $clog2(CLKS_PER_BIT);
  localparam int BYTE_W = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
  localparam logic [CNT_W-1:0]  BAUD_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [BYTE_W-1:0] BYTE_LAST = BYTE_W'(NUM_BYTES - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2:0]         bit_q, bit_d;
  logic [BYTE_W-1:0]  byte_q, byte_d;
  logic [31:0]        snap_q, snap_d;
  logic [31:0]        word_q, word_d;
  logic               tx_q, tx_d;
  logic               done_q, done_d;
  logic [7:0]         frames_q, frames_d;
  logic               baud_end;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    bit_d    = bit_q;
    byte_d   = byte_q;
    snap_d   = snap_q;
    word_d   = word_q;
    done_d   = 1'b0;
    frames_d = frames_q;
    baud_end = (cnt_q == BAUD_LAST);

    unique case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        // A resend request and a changed word both launch exactly one frame.
        if ((io.port_data != snap_q) || io.send_req) begin
          word_d  = io.port_data;
          snap_d  = io.port_data;
          byte_d  = '0;
          bit_d   = '0;
          state_d = S_START;
        end
      end
      S_START: begin
        if (baud_end) begin
          cnt_d   = '0;
          state_d = S_DATA;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_DATA: begin
        if (baud_end) begin
          cnt_d  = '0;
          // The word shifts right once per data bit, so bit 0 is always the
          // next bit on the wire, across byte boundaries as well.
          word_d = word_q >> 1;
          if (bit_q == 3'd7) begin
            bit_d   = '0;
            state_d = S_STOP;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_STOP: begin
        if (baud_end) begin
          cnt_d = '0;
          if (byte_q == BYTE_LAST) begin
            state_d  = S_IDLE;
            done_d   = 1'b1;
            frames_d = frames_q + 8'd1;
          end else begin
            byte_d  = byte_q + BYTE_W'(1);
            state_d = S_START;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    // tx is registered from the next state so the line level changes on the
    // same edge as the state and never glitches.
    unique case (state_d)
      S_START: tx_d = 1'b0;
      S_DATA:  tx_d = word_d[0];
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      bit_q    <= '0;
      byte_q   <= '0;
      snap_q   <= '0;
      tx_q     <= 1'b1;
      done_q   <= 1'b0;
      frames_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      bit_q    <= bit_d;
      byte_q   <= byte_d;
      snap_q   <= snap_d;
      tx_q     <= tx_d;
      done_q   <= done_d;
      frames_q <= frames_d;
    end
  end

  // The shift word is only meaningful while a frame is active and is always
  // loaded before use, so it carries no reset.
  always_ff @(posedge clk) begin
    word_q <= word_d;
  end

  assign io.tx          = tx_q;
  assign io.busy        = (state_q != S_IDLE);
  assign io.frame_done  = done_q;
  assign io.frames_sent = frames_q;

endmodule

// File: tb/tb_io_port_uart_tx.sv
module tb_io_port_uart_tx;

  localparam int CPB       = 4;
  localparam int FRAME_LEN = 4 * 10 * CPB;

  logic clk;
  logic rst;

  io_port_uart_tx_if io ();
  io_port_uart_tx_if io2 ();

  io_port_uart_tx #(.CLKS_PER_BIT(CPB), .NUM_BYTES(4)) dut (
    .clk (clk),
    .rst (rst),
    .io  (io)
  );

  io_port_uart_tx #(.CLKS_PER_BIT(2), .NUM_BYTES(4)) dut2 (
    .clk (clk),
    .rst (rst),
    .io  (io2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 20)
        $display("FAIL %s @%0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  // ---------------- reference model: frame timer + bit arithmetic ----------
  logic [31:0] m_snap, m_word;
  int          m_el;
  logic        m_act, m_done;
  logic [7:0]  m_cnt;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_snap <= '0;
      m_word <= '0;
      m_el   <= 0;
      m_act  <= 1'b0;
      m_done <= 1'b0;
      m_cnt  <= '0;
    end else begin
      m_done <= 1'b0;
      if (m_act) begin
        if (m_el == FRAME_LEN - 1) begin
          m_act  <= 1'b0;
          m_done <= 1'b1;
          m_cnt  <= m_cnt + 8'd1;
        end else begin
          m_el <= m_el + 1;
        end
      end else if ((io.port_data != m_snap) || io.send_req) begin
        m_act  <= 1'b1;
        m_el   <= 0;
        m_word <= io.port_data;
        m_snap <= io.port_data;
      end
    end
  end

  function automatic logic exp_tx(input logic act, input int el, input logic [31:0] w);
    int k;
    int pos;
    if (!act) return 1'b1;
    k   = el / CPB;
    pos = k % 10;
    if (pos == 0) return 1'b0;
    if (pos == 9) return 1'b1;
    return w[(k / 10) * 8 + pos - 1];
  endfunction

  always @(negedge clk) begin
    if (chk_en)
      check("cycle{tx,busy,done,cnt}",
            {53'd0, io.tx, io.busy, io.frame_done, io.frames_sent},
            {53'd0, exp_tx(m_act, m_el, m_word), m_act, m_done, m_cnt});
  end

  // ---------------- UART line decoder (mid-bit sampling) -------------------
  logic [7:0] rx_q[$];
  logic [7:0] rx_b;
  bit         rx_on = 0;
  int         rx_t  = 0;

  always @(negedge clk) begin
    if (rst) begin
      rx_on = 0;
    end else if (!rx_on) begin
      if (!io.tx) begin
        rx_on = 1;
        rx_t  = 0;
        rx_b  = '0;
      end
    end else begin
      rx_t++;
      if (rx_t % CPB == CPB / 2) begin
        if (rx_t / CPB >= 1 && rx_t / CPB <= 8) begin
          rx_b[rx_t / CPB - 1] = io.tx;
        end else if (rx_t / CPB == 9) begin
          if (io.tx) rx_q.push_back(rx_b);
          rx_on = 0;
        end
      end
    end
  end

  function automatic logic [63:0] rx_word();
    if (rx_q.size() != 4) return 64'hDEAD_0000_0000_0000 | 64'(rx_q.size());
    return {32'd0, rx_q[3], rx_q[2], rx_q[1], rx_q[0]};
  endfunction

  // ---------------- busy-run length monitor --------------------------------
  int run_len  = 0;
  int last_len = 0;

  always @(negedge clk) begin
    if (rst) run_len = 0;
    else if (io.busy) run_len++;
    else if (run_len != 0) begin
      last_len = run_len;
      run_len  = 0;
    end
  end

  // ---------------- helpers -------------------------------------------------
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_done(input int budget, output bit ok);
    ok = 0;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      if (io.frame_done) begin
        ok = 1;
        break;
      end
    end
  endtask

  task automatic pulse_req();
    @(negedge clk);
    io.send_req = 1'b1;
    @(negedge clk);
    io.send_req = 1'b0;
  endtask

  typedef struct {
    logic [31:0] data;
    logic        req;
    logic        exp_frame;
    logic [31:0] exp_word;
    logic [7:0]  exp_cnt;
  } vec_t;

  vec_t vecs[6];

  initial begin
    #2_000_000;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    bit ok;
    bit bad;
    int blen;
    int falls[$];
    logic prev;

    vecs[0] = '{32'hA5C3_0F81, 1'b0, 1'b1, 32'hA5C3_0F81, 8'd1};
    vecs[1] = '{32'hA5C3_0F81, 1'b1, 1'b1, 32'hA5C3_0F81, 8'd2};
    vecs[2] = '{32'hA5C3_0F81, 1'b0, 1'b0, 32'h0,         8'd2};
    vecs[3] = '{32'h0000_0000, 1'b0, 1'b1, 32'h0000_0000, 8'd3};
    vecs[4] = '{32'hFFFF_FFFF, 1'b0, 1'b1, 32'hFFFF_FFFF, 8'd4};
    vecs[5] = '{32'h1234_5678, 1'b1, 1'b1, 32'h1234_5678, 8'd5};

    rst = 1'b1;
    io.port_data  = '0;
    io.send_req   = 1'b0;
    io2.port_data = '0;
    io2.send_req  = 1'b0;
    tick(3);
    rst = 1'b0;
    chk_en = 1;

    // reset state
    check("reset tx", io.tx, 1);
    check("reset busy", io.busy, 0);
    check("reset frames_sent", io.frames_sent, 0);
    check("reset frame_done", io.frame_done, 0);

    // quiet port after reset: no frame
    bad = 0;
    for (int c = 0; c < 500; c++) begin
      @(negedge clk);
      if (io.busy || !io.tx) bad = 1;
    end
    check("idle 500 cycles quiet", bad, 0);
    check("idle frames_sent", io.frames_sent, 0);

    // CLKS_PER_BIT=2 instance: 20-cycle bytes, 80-cycle frame
    @(negedge clk);
    io2.port_data = 32'hFFFF_FFFF;
    blen = 0;
    prev = 1'b1;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (io2.busy) blen++;
      if (prev && !io2.tx) falls.push_back(c);
      prev = io2.tx;
    end
    check("cpb2 busy length", blen, 80);
    check("cpb2 start bits", falls.size(), 4);
    if (falls.size() == 4) begin
      check("cpb2 byte0->1 spacing", falls[1] - falls[0], 20);
      check("cpb2 byte2->3 spacing", falls[3] - falls[2], 20);
    end
    check("cpb2 frames_sent", io2.frames_sent, 1);

    // table-driven frames
    for (int i = 0; i < 6; i++) begin
      rx_q.delete();
      @(negedge clk);
      io.port_data = vecs[i].data;
      io.send_req  = vecs[i].req;
      @(negedge clk);
      io.send_req  = 1'b0;
      if (vecs[i].exp_frame) begin
        wait_done(FRAME_LEN + 20, ok);
        check($sformatf("vec%0d frame_done", i), ok, 1);
        tick(2);
        check($sformatf("vec%0d busy length", i), last_len, FRAME_LEN);
        check($sformatf("vec%0d decoded word", i), rx_word(), {32'd0, vecs[i].exp_word});
      end else begin
        tick(300);
        check($sformatf("vec%0d no bytes", i), rx_q.size(), 0);
      end
      check($sformatf("vec%0d frames_sent", i), io.frames_sent, vecs[i].exp_cnt);
    end

    // resend request while busy is ignored
    rx_q.delete();
    pulse_req();
    tick(50);
    pulse_req();
    wait_done(FRAME_LEN + 20, ok);
    check("midreq frame_done", ok, 1);
    tick(300);
    check("midreq single frame", io.frames_sent, 6);
    check("midreq decoded word", rx_word(), {32'd0, 32'h1234_5678});

    // changes during a frame collapse to the latest value
    rx_q.delete();
    @(negedge clk);
    io.port_data = 32'hCAFE_F00D;
    tick(30);
    io.port_data = 32'h1111_1111;
    tick(30);
    io.port_data = 32'h2222_2222;
    wait_done(FRAME_LEN + 20, ok);
    check("collapse first done", ok, 1);
    check("collapse first word", rx_word(), {32'd0, 32'hCAFE_F00D});
    rx_q.delete();
    wait_done(FRAME_LEN + 20, ok);
    check("collapse second done", ok, 1);
    check("collapse second word", rx_word(), {32'd0, 32'h2222_2222});
    tick(300);
    check("collapse frames_sent", io.frames_sent, 8);
    check("collapse no third frame", rx_q.size(), 4);

    // reset during byte 2 data bits
    rx_q.delete();
    @(negedge clk);
    io.port_data = 32'hDEAD_BEEF;
    @(negedge clk);
    repeat (90) @(posedge clk);
    check("pre-reset busy", io.busy, 1);
    #1;
    rst = 1'b1;
    #1;
    check("midreset tx", io.tx, 1);
    check("midreset busy", io.busy, 0);
    check("midreset frames_sent", io.frames_sent, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    rx_q.delete();
    wait_done(FRAME_LEN + 20, ok);
    check("postreset frame_done", ok, 1);
    tick(2);
    check("postreset busy length", last_len, FRAME_LEN);
    check("postreset word", rx_word(), {32'd0, 32'hDEAD_BEEF});
    check("postreset frames_sent", io.frames_sent, 1);

    // 255 more frames: counter reaches 255 then wraps to 0
    for (int i = 0; i < 255; i++) begin
      pulse_req();
      wait_done(FRAME_LEN + 20, ok);
      check("wrap frame_done", ok, 1);
      if (i == 253) check("wrap count 255", io.frames_sent, 255);
    end
    tick(2);
    check("wrap count 0", io.frames_sent, 0);
    check("wrap idle", io.busy, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
